// File: rtl/serial_loader.sv
// serial_loader: receives a length-prefixed program image over an 8N1 serial
// line and streams it into program RAM, then pulses run to start the CPU.
// Image format: len[7:0], len[15:8], then len data bytes written at 0..len-1.
module serial_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              run,
  output logic              err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {H_LO, H_HI, DATA, DONE} img_state_t;

  // Synchronizer flops (idle-high line, so they reset to 1)
  logic rx_meta_q, rxs_q;

  // Bit receiver state
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_v;
  logic          frame_err;

  // Image state
  img_state_t        img_q, img_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       idx_q, idx_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              run_q, run_d;
  logic              err_q, err_d;

  // Bring the asynchronous serial line into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  // Bit timing: sample mid-bit; byte_v/frame_err fire in the stop-sample cycle
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_v     = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) rx_state_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          rx_state_d = rxs_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          rx_state_d = R_IDLE;
          if (rxs_q) byte_v    = 1'b1;
          else       frame_err = 1'b1;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Image parsing: header, sequential RAM writes, and the run handshake
  always_comb begin
    img_d     = img_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    run_d     = 1'b0;
    err_d     = err_q;

    // run fires exactly once: the first cycle DONE is seen while done is still low
    if (img_q == DONE && !done_q) begin
      run_d  = 1'b1;
      done_d = 1'b1;
    end

    if (frame_err) begin
      err_d = 1'b1;
      // A loaded image is final; a bad frame after it only raises err
      if (img_q != DONE) begin
        img_d     = H_LO;
        idx_d     = '0;
        wr_addr_d = '0;
        busy_d    = 1'b0;
      end
    end else if (byte_v) begin
      case (img_q)
        H_LO: begin
          len_d[7:0] = shift_q;
          busy_d     = 1'b1;
          img_d      = H_HI;
        end
        H_HI: begin
          len_d[15:8] = shift_q;
          idx_d       = '0;
          if ({shift_q, len_q[7:0]} == 16'd0) begin
            img_d  = DONE;
            busy_d = 1'b0;
          end else begin
            img_d = DATA;
          end
        end
        DATA: begin
          wr_en_d   = 1'b1;
          wr_data_d = shift_q;
          wr_addr_d = ADDR_W'(idx_q);
          idx_d     = idx_q + 16'd1;
          if (idx_q == len_q - 16'd1) begin
            img_d  = DONE;
            busy_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers for the receiver and the image FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= R_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      img_q      <= H_LO;
      len_q      <= '0;
      idx_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      img_q      <= img_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      run_q      <= run_d;
      err_q      <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign run     = run_q;
  assign err     = err_q;

endmodule

// File: tb/tb_serial_loader.sv
// Testbench for serial_loader: directed frames, expected writes/run pulses
// queued as stimulus is issued and checked by an independent monitor.
module tb_serial_loader;

  localparam int N      = 16;
  localparam int ADDR_W = 16;

  logic              clk;
  logic              rst_n;
  logic              rxd;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic              run;
  logic              err;

  serial_loader #(.CLKS_PER_BIT(N), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rxd     (rxd),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .run     (run),
    .err     (err)
  );

  typedef struct {
    bit          is_run;
    bit          after_wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int last_fall_cyc = 0;
  int last_wr_cyc   = 0;
  bit prev_wr    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index of the edge that started the current cycle
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void pushWrite(input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.is_run = 1'b0; e.after_wr = 1'b0; e.addr = a; e.data = d;
    sb.push_back(e);
  endfunction

  function automatic void pushRun(input bit after_wr);
    exp_t e;
    e.is_run = 1'b1; e.after_wr = after_wr; e.addr = '0; e.data = '0;
    sb.push_back(e);
  endfunction

  // Monitor: every wr_en or run pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (wr_en) begin
        last_wr_cyc = cyc;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_wr: got addr %0h data %0h, required no write", wr_addr, wr_data);
        end else begin
          e = sb.pop_front();
          vectors--;
          if (e.is_run) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL wr_order: got write addr %0h, required run pulse", wr_addr);
          end else begin
            checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
            checkOutput("wr_data", 32'(wr_data), 32'(e.data));
          end
        end
      end
      if (run) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_run: got run=1, required run=0");
        end else begin
          e = sb.pop_front();
          if (!e.is_run) begin
            miscompares++;
            $display("[TB] FAIL run_order: got run pulse, required write addr %0h data %0h", e.addr, e.data);
          end else if (e.after_wr) begin
            vectors--;
            checkOutput("run_after_wr", 32'(prev_wr), 32'd1);
          end
        end
      end
      prev_wr = wr_en;
    end else begin
      prev_wr = 1'b0;
    end
  end

  // Send one 8N1 frame; stop_bit=0 makes a framing error
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(posedge clk); #1;
    last_fall_cyc = cyc;
    rxd = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (N) @(posedge clk);
      #1;
    end
    rxd = stop_bit;
    repeat (N) @(posedge clk);
    #1;
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    rxd   = 1'b1;
    rst_n = 1'b0;
    idle(3);

    // Reset values
    checkOutput("rst_wr_en",   32'(wr_en),   32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_busy",    32'(busy),    32'd0);
    checkOutput("rst_done",    32'(done),    32'd0);
    checkOutput("rst_run",     32'(run),     32'd0);
    checkOutput("rst_err",     32'(err),     32'd0);
    rst_n = 1'b1;
    idle(4);

    // Basic image: 3 bytes at 0..2, then run right after the last write
    $display("[TB] basic image");
    pushWrite(16'd0, 8'hA1);
    pushWrite(16'd1, 8'hB2);
    pushWrite(16'd2, 8'hC3);
    pushRun(1'b1);
    applyStimulus(8'h03);
    checkOutput("busy_after_hdr", 32'(busy), 32'd1);
    applyStimulus(8'h00);
    applyStimulus(8'hA1);
    // rxd falls in cycle F; synchronizer makes T0 = F+2; wr_en at T0+153
    checkOutput("wr_latency", 32'(last_wr_cyc - last_fall_cyc), 32'd155);
    applyStimulus(8'hB2);
    applyStimulus(8'hC3);
    idle(8);
    checkOutput("basic_done", 32'(done), 32'd1);
    checkOutput("basic_busy", 32'(busy), 32'd0);
    checkOutput("basic_err",  32'(err),  32'd0);
    checkOutput("basic_sb_empty", 32'(sb.size()), 32'd0);

    // Zero-length image: header only, straight to run
    $display("[TB] zero length");
    doReset();
    pushRun(1'b0);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    idle(8);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    checkOutput("zero_sb_empty", 32'(sb.size()), 32'd0);

    // False start: 2-cycle glitch must be rejected, then a normal image
    $display("[TB] false start");
    doReset();
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(40);
    checkOutput("glitch_busy", 32'(busy), 32'd0);
    checkOutput("glitch_err",  32'(err),  32'd0);
    pushWrite(16'd0, 8'h5A);
    pushRun(1'b1);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h5A);
    idle(8);
    checkOutput("glitch_done", 32'(done), 32'd1);
    checkOutput("glitch_sb_empty", 32'(sb.size()), 32'd0);

    // Framing error mid-image restarts the header and clears the address
    $display("[TB] framing error");
    doReset();
    pushWrite(16'd0, 8'h11);
    pushWrite(16'd1, 8'h22);
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    checkOutput("fe_addr_before", 32'(wr_addr), 32'd1);
    applyStimulus(8'h33, 1'b0);
    idle(30);
    checkOutput("fe_err",     32'(err),     32'd1);
    checkOutput("fe_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("fe_done",    32'(done),    32'd0);
    pushWrite(16'd0, 8'h5A);
    pushRun(1'b1);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h5A);
    idle(8);
    checkOutput("fe_reload_done", 32'(done), 32'd1);
    checkOutput("fe_err_sticky",  32'(err),  32'd1);
    checkOutput("fe_sb_empty", 32'(sb.size()), 32'd0);

    // Bytes after DONE are ignored
    $display("[TB] post done");
    applyStimulus(8'hFF);
    idle(8);
    checkOutput("post_done", 32'(done), 32'd1);
    checkOutput("post_busy", 32'(busy), 32'd0);
    checkOutput("post_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of the second data byte
    $display("[TB] reset mid-load");
    doReset();
    pushWrite(16'd0, 8'hD0);
    applyStimulus(8'h04);
    applyStimulus(8'h00);
    applyStimulus(8'hD0);
    @(posedge clk); #1;
    rxd = 1'b0;
    idle(3 * N);
    rxd = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_busy",    32'(busy),    32'd0);
    checkOutput("async_wr_data", 32'(wr_data), 32'd0);
    checkOutput("async_wr_en",   32'(wr_en),   32'd0);
    checkOutput("async_done",    32'(done),    32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(4);
    pushWrite(16'd0, 8'h10);
    pushWrite(16'd1, 8'h20);
    pushWrite(16'd2, 8'h30);
    pushWrite(16'd3, 8'h40);
    pushRun(1'b1);
    applyStimulus(8'h04);
    applyStimulus(8'h00);
    applyStimulus(8'h10);
    applyStimulus(8'h20);
    applyStimulus(8'h30);
    applyStimulus(8'h40);
    idle(8);
    checkOutput("reload_done", 32'(done), 32'd1);
    checkOutput("reload_addr", 32'(wr_addr), 32'd3);
    checkOutput("reload_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
